// File: rtl/prbs_pkg.sv
`default_nettype none
// ============================================================================
// Module  : prbs_pkg
// Purpose : Definitions shared by the 16-bit Galois LFSR pattern generator
//           and checker: widths, default polynomial and seed, checker state
//           encoding, the LFSR step function and a 16-bit popcount.
// Revision: 1.0 - initial release
// ============================================================================
package prbs_pkg;

   localparam int              PRBS_W            = 16;
   localparam logic [PRBS_W-1:0] PRBS_POLY_DEFAULT = 16'hB400;
   localparam logic [PRBS_W-1:0] PRBS_SEED_DEFAULT = 16'hACE1;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } prbs_state_t;

   // One Galois right-shift step: shift out bit 0 and fold it back through poly.
   function automatic logic [PRBS_W-1:0] lfsr_step(input logic [PRBS_W-1:0] x,
                                                     input logic [PRBS_W-1:0] poly);
      return x[0] ? ((x >> 1) ^ poly) : (x >> 1);
   endfunction

   // Number of set bits in a 16-bit word (0..16).
   function automatic logic [4:0] popcount16(input logic [15:0] x);
      logic [4:0] cnt;
      cnt = 5'd0;
      for (int i = 0; i < 16; i++) begin
         cnt = cnt + {4'd0, x[i]};
      end
      return cnt;
   endfunction

endpackage : prbs_pkg
`default_nettype wire

// File: rtl/prbs_checker.sv
`default_nettype none
// ============================================================================
// Module  : prbs_checker
// Purpose : Receive-side checker for the 16-bit Galois LFSR pattern source.
//           Seeds itself from the incoming stream, confirms LOCK_COUNT
//           consecutive matches, then flywheels a local reference and
//           counts mismatching words (saturating).
// Build   : define PRBS_CHK_BITERR_EN to weight each error by the number of
//           wrong bits instead of counting one per mismatching word.
// Revision: 1.0 - initial release
// ============================================================================
module prbs_checker
   import prbs_pkg::*;
#(
   parameter logic [PRBS_W-1:0] POLY         = PRBS_POLY_DEFAULT,
   parameter int                LOCK_COUNT   = 4,
   parameter int                UNLOCK_COUNT = 4,
   parameter int                ERR_W        = 16
) (
   input  logic              clk,
   input  logic              n_reset,
   input  logic [PRBS_W-1:0] din,
   input  logic              din_valid,
   input  logic              clear_cnt,
   output logic              locked,
   output logic              err_pulse,
   output logic [ERR_W-1:0]  err_count
);

   prbs_state_t       r_state;
   prbs_state_t       w_state_nxt;
   logic [PRBS_W-1:0] r_ref;
   logic [PRBS_W-1:0] w_ref_nxt;
   logic [3:0]        r_good_cnt;
   logic [3:0]        w_good_nxt;
   logic [3:0]        r_bad_cnt;
   logic [3:0]        w_bad_nxt;
   logic              r_err_pulse;
   logic              w_pulse_nxt;
   logic [ERR_W-1:0]  r_err_count;
   logic [ERR_W-1:0]  w_count_nxt;

   logic [PRBS_W-1:0] w_expect;
   logic              w_match;
   logic [3:0]        w_good_inc;
   logic [3:0]        w_bad_inc;
   logic [4:0]        w_weight;
   logic [ERR_W-1:0]  w_count_base;
   logic [ERR_W:0]    w_count_sum;
   logic [ERR_W-1:0]  w_count_add;

   assign w_expect   = lfsr_step(r_ref, POLY);
   assign w_match    = (din == w_expect);
   assign w_good_inc = r_good_cnt + 4'd1;
   assign w_bad_inc  = r_bad_cnt + 4'd1;

`ifdef PRBS_CHK_BITERR_EN
   assign w_weight = popcount16(din ^ w_expect);
`else
   assign w_weight = 5'd1;
`endif

   // Clear acts first (and independently of din_valid); an error in the same
   // cycle then adds on top of zero. The extra sum bit detects overflow.
   assign w_count_base = clear_cnt ? '0 : r_err_count;
   assign w_count_sum  = {1'b0, w_count_base} + (ERR_W+1)'(w_weight);
   assign w_count_add  = w_count_sum[ERR_W] ? '1 : w_count_sum[ERR_W-1:0];

   // Next-state and next-counter logic; nothing moves without din_valid.
   always_comb begin
      w_state_nxt = r_state;
      w_ref_nxt   = r_ref;
      w_good_nxt  = r_good_cnt;
      w_bad_nxt   = r_bad_cnt;
      w_pulse_nxt = 1'b0;
      w_count_nxt = w_count_base;
      if (din_valid) begin
         unique case (r_state)
            HUNT: begin
               // All-zero is the LFSR lockup word and cannot seed.
               if (din != '0) begin
                  w_ref_nxt   = din;
                  w_good_nxt  = 4'd0;
                  w_state_nxt = VERIFY;
               end
            end
            VERIFY: begin
               if (din == '0) begin
                  w_state_nxt = HUNT;
               end else if (w_match) begin
                  w_ref_nxt  = din;
                  w_good_nxt = w_good_inc;
                  if (w_good_inc == 4'(LOCK_COUNT)) begin
                     w_state_nxt = LOCKED;
                  end
               end else begin
                  w_ref_nxt  = din;
                  w_good_nxt = 4'd0;
               end
            end
            LOCKED: begin
               // Flywheel: the reference advances regardless of what arrived.
               w_ref_nxt = w_expect;
               if (w_match) begin
                  w_bad_nxt = 4'd0;
               end else begin
                  w_pulse_nxt = 1'b1;
                  w_count_nxt = w_count_add;
                  w_bad_nxt   = w_bad_inc;
                  if (w_bad_inc == 4'(UNLOCK_COUNT)) begin
                     w_state_nxt = HUNT;
                     w_good_nxt  = 4'd0;
                     w_bad_nxt   = 4'd0;
                  end
               end
            end
            default: begin
               w_state_nxt = HUNT;
            end
         endcase
      end
   end

   // State, reference and counter registers.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_state     <= HUNT;
         r_ref       <= '0;
         r_good_cnt  <= 4'd0;
         r_bad_cnt   <= 4'd0;
         r_err_pulse <= 1'b0;
         r_err_count <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_ref       <= w_ref_nxt;
         r_good_cnt  <= w_good_nxt;
         r_bad_cnt   <= w_bad_nxt;
         r_err_pulse <= w_pulse_nxt;
         r_err_count <= w_count_nxt;
      end
   end

   assign locked    = (r_state == LOCKED);
   assign err_pulse = r_err_pulse;
   assign err_count = r_err_count;

endmodule : prbs_checker
`default_nettype wire
